// File: rtl/spi_master_ctrl_if.sv
// Host/SPI signal bundle for spi_master_ctrl.
// master: the sequencer side. slave: the host/peripheral side.
interface spi_master_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  cpol;
  logic                  cpha;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  miso;
  logic                  sclk;
  logic                  ss_n;
  logic                  reg_en;
  logic                  rs;
  logic                  mosi;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, cpol, cpha, tx_data, miso,
    output sclk, ss_n, reg_en, rs, mosi,
    output rx_data, busy, done
  );

  modport slave (
    output start, cpol, cpha, tx_data, miso,
    input  sclk, ss_n, reg_en, rs, mosi,
    input  rx_data, busy, done
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: one MSB-first transfer per start,
// all four CPOL/CPHA modes, SCLK = clk / (2*CLK_DIV).
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic            clk,
  input  logic            reset,
  spi_master_ctrl_if.master bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDG_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);
  localparam logic [EDG_W-1:0] EDG_LAST = EDG_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DIV_W-1:0]      r_div;
  logic [EDG_W-1:0]      r_edge;
  logic                  r_sclk;
  logic                  r_cpol;
  logic                  r_cpha;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;

  logic w_tc;
  logic w_tog;
  logic w_odd;
  logic w_last;
  logic w_first;
  logic w_cap;
  logic w_shift;
  logic w_accept;
  logic w_sclk;
  logic w_ss_n;
  logic w_reg_en;
  logic w_busy;
  logic w_done;

  assign w_tc     = (r_div == DIV_TC);
  assign w_tog    = (r_state == S_XFER) && w_tc;
  assign w_odd    = ~r_edge[0];
  assign w_last   = (r_edge == EDG_LAST);
  assign w_first  = (r_edge == '0);
  assign w_accept = (r_state == S_IDLE) && bus.start;

  // Toggle n = r_edge+1; odd toggles are leading edges.
  assign w_cap   = r_cpha ? ~w_odd : w_odd;
  assign w_shift = r_cpha ? (w_odd && !w_first)
                          : (!w_odd && !w_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SETUP;
      S_SETUP: if (w_tc) w_next = S_XFER;
      S_XFER:  if (w_tc && w_last) w_next = S_HOLD;
      S_HOLD:  if (w_tc) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sclk   = r_cpol;
    w_ss_n   = 1'b1;
    w_reg_en = 1'b0;
    w_busy   = 1'b1;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE:  w_busy = 1'b0;
      S_SETUP: w_ss_n = 1'b0;
      S_XFER: begin
        w_ss_n   = 1'b0;
        w_reg_en = 1'b1;
        w_sclk   = r_sclk;
      end
      S_HOLD:  w_ss_n = 1'b0;
      S_DONE:  w_done = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_edge    <= '0;
      r_sclk    <= 1'b0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
    end else begin
      if (r_state == S_IDLE || r_state == S_DONE || w_tc)
        r_div <= '0;
      else
        r_div <= r_div + DIV_W'(1);

      if (r_state == S_IDLE) begin
        r_edge <= '0;
        r_cpol <= bus.cpol;
        r_cpha <= bus.cpha;
      end else if (w_tog) begin
        r_edge <= r_edge + EDG_W'(1);
      end

      if (r_state == S_SETUP) r_sclk <= r_cpol;
      else if (w_tog)         r_sclk <= ~r_sclk;

      if (w_accept) begin
        r_tx <= bus.tx_data;
        r_rx <= '0;
      end else if (w_tog) begin
        if (w_shift) r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
        if (w_cap)   r_rx <= {r_rx[DATA_WIDTH-2:0], bus.miso};
      end

      if (r_state == S_HOLD && w_tc) r_rx_data <= r_rx;
    end
  end

  assign bus.sclk    = w_sclk;
  assign bus.ss_n    = w_ss_n;
  assign bus.reg_en  = w_reg_en;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.rs      = ~(r_cpol ^ r_cpha);
  assign bus.mosi    = r_tx[DATA_WIDTH-1];
  assign bus.rx_data = r_rx_data;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: CLK_DIV=4 unit with
// an SPI slave model or loopback, plus a CLK_DIV=1 loopback unit.
module tb_spi_master_ctrl;
  localparam int DW  = 8;
  localparam int PER = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(PER/2) clk = ~clk;

  spi_master_ctrl_if #(.DATA_WIDTH(DW)) bus ();
  spi_master_ctrl_if #(.DATA_WIDTH(DW)) bus1 ();

  spi_master_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(4)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  spi_master_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );

  typedef struct {
    logic [DW-1:0] rx;
    logic [DW-1:0] srx;
    bit            chk_s;
    logic          idle;
    logic          rs;
    int            cyc;
    time           t0;
    int            tog;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0;
  exp_t m1;

  int checks = 0;
  int errors = 0;
  int ndone0 = 0;
  int ndone1 = 0;
  int tog0 = 0;
  int tog1 = 0;

  logic          r_loop = 1'b0;
  logic          s_cpol = 1'b0;
  logic          s_cpha = 1'b0;
  logic          s_miso = 1'b0;
  logic [DW-1:0] s_tx = '0;
  logic [DW-1:0] s_rx = '0;
  int            s_idx = 0;
  logic          p_ss = 1'b1;
  bit            g_ss = 1'b0;
  bit            g_rs = 1'b0;

  assign bus.miso  = r_loop ? bus.mosi : s_miso;
  assign bus1.miso = bus1.mosi;
  assign bus1.cpol = 1'b0;
  assign bus1.cpha = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // SPI slave: samples mosi on its sample edge, drives miso on the other.
  always @(bus.sclk or bus.ss_n) begin
    if (bus.ss_n !== p_ss) begin
      p_ss = bus.ss_n;
      if (bus.ss_n === 1'b0) begin
        s_idx = 0;
        s_rx  = '0;
        if (!s_cpha) begin
          s_miso = s_tx[DW-1];
          s_idx  = 1;
        end
      end
    end else if (bus.ss_n === 1'b0) begin
      if ((bus.sclk !== s_cpol) ^ s_cpha)
        s_rx = {s_rx[DW-2:0], bus.mosi};
      else if (s_idx < DW) begin
        s_miso = s_tx[DW-1-s_idx];
        s_idx++;
      end
    end
  end

  always @(bus.sclk) if (bus.ss_n === 1'b0) tog0++;
  always @(bus1.sclk) if (bus1.busy === 1'b1) tog1++;

  always @(negedge clk) begin
    if (!rst && q0.size() > 0 && bus.busy === 1'b1 && bus.done !== 1'b1) begin
      if (bus.ss_n !== 1'b0) g_ss = 1'b1;
      if (bus.rs !== q0[0].rs) g_rs = 1'b1;
    end
    if (bus.done === 1'b1) begin
      ndone0++;
      chk("sb0_nonempty", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        m0 = q0.pop_front();
        chk("rx_data", bus.rx_data, m0.rx);
        if (m0.chk_s) chk("slave_rx", s_rx, m0.srx);
        chk("done_cycle", int'(($time - m0.t0 - PER/2) / PER) + 1, m0.cyc);
        chk("sclk_toggles", tog0, m0.tog);
        chk("sclk_idle", bus.sclk, m0.idle);
        chk("ss_n_glitch", g_ss, 0);
        chk("rs_busy", g_rs, 0);
        g_ss = 1'b0;
        g_rs = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.done === 1'b1) begin
      ndone1++;
      chk("sb1_nonempty", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        m1 = q1.pop_front();
        chk("div1_rx_data", bus1.rx_data, m1.rx);
        chk("div1_done_cycle", int'(($time - m1.t0 - PER/2) / PER) + 1, m1.cyc);
        chk("div1_toggles", tog1, m1.tog);
      end
    end
  end

  task automatic xfer(input logic [DW-1:0] tx, input logic [DW-1:0] stx,
                      input logic [DW-1:0] erx, input logic [DW-1:0] esrx,
                      input bit chk_s, input logic cpol, input logic cpha,
                      input logic loop, input logic ers);
    exp_t e;
    @(negedge clk);
    bus.cpol    = cpol;
    bus.cpha    = cpha;
    bus.tx_data = tx;
    r_loop      = loop;
    s_tx        = stx;
    s_cpol      = cpol;
    s_cpha      = cpha;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    e.rx    = erx;
    e.srx   = esrx;
    e.chk_s = chk_s;
    e.idle  = cpol;
    e.rs    = ers;
    e.cyc   = 73;
    e.t0    = $time;
    e.tog   = tog0 + 16;
    q0.push_back(e);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 300 && ndone0 == base; i++) @(negedge clk);
    chk("done_timeout", ndone0 != base, 1);
  endtask

  int b;
  exp_t e1;

  initial begin
    bus.start    = 1'b0;
    bus.cpol     = 1'b0;
    bus.cpha     = 1'b0;
    bus.tx_data  = '0;
    bus1.start   = 1'b0;
    bus1.tx_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_ss_n", bus.ss_n, 1);
    chk("rst_reg_en", bus.reg_en, 0);
    chk("rst_rs", bus.rs, 1);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;

    b = ndone0;
    xfer(8'hA5, 8'h00, 8'hA5, 8'h00, 0, 0, 0, 1, 1);
    wait_done(b);

    b = ndone0;
    xfer(8'hC3, 8'h3C, 8'h3C, 8'hC3, 1, 1, 1, 0, 1);
    wait_done(b);

    b = ndone0;
    xfer(8'h81, 8'h7E, 8'h7E, 8'h81, 1, 0, 1, 0, 0);
    wait_done(b);

    b = ndone0;
    xfer(8'h81, 8'h7E, 8'h7E, 8'h81, 1, 1, 0, 0, 0);
    wait_done(b);

    b = ndone0;
    xfer(8'h5A, 8'h00, 8'h5A, 8'h00, 0, 0, 0, 1, 1);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (62) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("one_done", ndone0 - b, 1);
    chk("idle_after_ignored", bus.busy, 0);

    @(negedge clk);
    bus.cpol    = 1'b1;
    bus.cpha    = 1'b1;
    bus.tx_data = 8'h55;
    s_cpol      = 1'b1;
    s_cpha      = 1'b1;
    r_loop      = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_sclk", bus.sclk, 0);
    chk("abort_ss_n", bus.ss_n, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_reg_en", bus.reg_en, 0);
    chk("abort_rx_data", bus.rx_data, 0);
    @(negedge clk);
    rst = 1'b0;

    b = ndone0;
    xfer(8'h3C, 8'h00, 8'h3C, 8'h00, 0, 0, 0, 1, 1);
    wait_done(b);

    b = ndone1;
    @(negedge clk);
    bus1.tx_data = 8'hFF;
    bus1.start   = 1'b1;
    @(posedge clk);
    e1.rx    = 8'hFF;
    e1.srx   = '0;
    e1.chk_s = 1'b0;
    e1.idle  = 1'b0;
    e1.rs    = 1'b1;
    e1.cyc   = 19;
    e1.t0    = $time;
    e1.tog   = tog1 + 16;
    q1.push_back(e1);
    #1 bus1.start = 1'b0;
    for (int i = 0; i < 100 && ndone1 == b; i++) @(negedge clk);
    chk("div1_timeout", ndone1 != b, 1);

    repeat (3) @(negedge clk);
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(PER * 20000);
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end
endmodule
